axi_ar_sched: RTL and testbench
===============================

AXI_AR_SCHED -- requirements
Module: axi_ar_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-002 SHALL have parameter BEAT_BYTES, default 16, bytes per data beat (128-bit bus).
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum beats per AR burst.
REQ-004 SHALL have port I_clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port I_rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports I_req0_start / I_req1_start  input  1  one-cycle job start per requester.
REQ-007 SHALL have ports I_req0_addr / I_req1_addr  input  ADDR_W  job byte start address, sampled with start.
REQ-008 SHALL have ports I_req0_beats / I_req1_beats  input  16  job length in beats, sampled with start.
REQ-009 SHALL have ports O_req0_busy / O_req1_busy  output  1  job accepted and not finished.
REQ-010 SHALL have ports O_req0_done / O_req1_done  output  1  one-cycle pulse, all bursts of the job handshaken.
REQ-011 SHALL have port O_arvalid  output  1  AR channel valid.
REQ-012 SHALL have port I_arready  input  1  AR channel ready.
REQ-013 SHALL have port O_araddr  output  ADDR_W  burst byte address.
REQ-014 SHALL have port O_arlen  output  8  burst beats minus one.
REQ-015 SHALL have port O_arid  output  1  index of granted requester.

Function
REQ-016 SHALL accept start only while that requester's busy is low; start while busy is ignored; busy rises on the edge sampling start.
REQ-017 SHALL force the low log2(BEAT_BYTES) bits of a latched address to zero.
REQ-018 SHALL implement FSM IDLE, ARB, ISSUE; IDLE->ARB when any requester has remaining beats; ARB->ISSUE always; ISSUE->ARB on handshake if beats remain anywhere, else ->IDLE.
REQ-019 SHALL, in ARB, grant round-robin per burst: when both are pending, grant the one not granted last; pointer after reset favours req0.
REQ-020 SHALL compute burst beats = min(remaining, MAX_BURST, beats to next 4 KB boundary); O_arlen = beats-1.
REQ-021 SHALL hold O_arvalid, O_araddr, O_arlen, O_arid high/stable in ISSUE until the cycle I_arready is high.
REQ-022 SHALL, on handshake, advance granted address by beats*BEAT_BYTES (modulo 2^ADDR_W) and reduce remaining by beats.
REQ-023 SHALL, when remaining reaches 0 on a handshake, pulse done for one cycle and drop busy on the same edge; a start in that done cycle is accepted.
REQ-024 SHALL, for beats=0, pulse done on the edge after start, drop busy, and issue no burst.
REQ-025 SHALL, from IDLE, assert O_arvalid exactly 2 edges after the edge that accepted start.
REQ-026 SHALL honour a start from the non-granted requester in the same cycle as an AR handshake.
REQ-027 SHALL keep O_arvalid low outside ISSUE.

Reset
REQ-028 SHALL, with I_rst_n low at an edge, set FSM IDLE, busy/done/O_arvalid 0, O_araddr/O_arlen/O_arid 0, remaining 0, RR pointer to favour req0.
REQ-029 SHALL, on reset mid-ISSUE, drop O_arvalid at that edge and emit no done for aborted jobs.

Structure
REQ-030 SHALL take BEAT_BYTES, MAX_BURST, PAGE_BYTES=4096 and FSM state encodings from shared package cnna_axi_pkg.
REQ-031 SHALL instantiate sub-module axi_ar_req_ctx twice (latch addr/remaining, busy, done, burst-beat compute).

Verification
REQ-032 SHALL cover: req0 addr 0x1000 beats 40, arready=1 -> AR (0x1000,15),(0x1100,15),(0x1200,7), id 0; req0_done after third handshake.
REQ-033 SHALL cover: req0 addr 0x0FC0 beats 10 -> AR (0x0FC0,3),(0x1000,5).
REQ-034 SHALL cover: both start same cycle, addr 0x0 / 0x8000, beats 32 each -> ids 0,1,0,1; addrs 0x0,0x8000,0x100,0x8100.
REQ-035 SHALL cover: arready low 5 cycles in ISSUE -> arvalid/araddr/arlen/arid unchanged all 5 cycles.
REQ-036 SHALL cover: req1 beats 0 -> done pulse one edge after start, no arvalid.
REQ-037 SHALL cover: I_rst_n low during ISSUE of 40-beat job -> arvalid 0 next edge, busy 0, no done; restart works normally.

Source files
------------

// File: rtl/cnna_axi_pkg.sv
// Shared AXI read-address scheduling definitions.
// Purpose: holds the default bus geometry, the 4 KB page size that bursts
//          must not cross, the AR scheduler FSM encoding and a small helper
//          for picking the shorter of two beat counts.
// Ports:   none (package).
package cnna_axi_pkg;

  localparam int AXI_BEAT_BYTES = 16;
  localparam int AXI_MAX_BURST  = 16;
  localparam int PAGE_BYTES     = 4096;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_ISSUE = 2'd2
  } ar_state_e;

  function automatic logic [15:0] min_beats(input logic [15:0] a, input logic [15:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_ar_req_ctx.sv
// Per-requester job context for the AR scheduler.
// Purpose: latches a job (beat-aligned address, remaining beats), tracks
//          busy, pulses done when the last burst is handshaken, and computes
//          the size of the next burst for this requester.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             one-cycle job start (ignored while busy)
//   start_addr        job byte address, sampled with start
//   start_beats       job length in beats, sampled with start
//   handshake         AR handshake of a burst belonging to this requester
//   busy, done        job in flight / one-cycle completion pulse
//   pending           beats still waiting to be issued
//   addr              byte address of the next burst
//   burst_beats       beats in the next burst
//   last_burst        next burst finishes the job
module axi_ar_req_ctx
  import cnna_axi_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int BEAT_BYTES = AXI_BEAT_BYTES,
  parameter int MAX_BURST  = AXI_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [15:0]       start_beats,
  input  logic              handshake,
  output logic              busy,
  output logic              done,
  output logic              pending,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       burst_beats,
  output logic              last_burst
);

  localparam int BEAT_SH = $clog2(BEAT_BYTES);
  localparam int PAGE_W  = $clog2(PAGE_BYTES);
  localparam logic [PAGE_W:0]   PAGE_FULL  = PAGE_BYTES[PAGE_W:0];
  localparam logic [15:0]       MAX_V      = 16'(MAX_BURST);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BEAT_BYTES - 1);

  logic [15:0]       remaining;
  logic [15:0]       rem_next;
  logic [PAGE_W:0]   page_room;
  logic [15:0]       page_beats;
  logic [ADDR_W-1:0] step;

  // Bytes left before the next 4 KB boundary; one extra bit because an
  // address sitting exactly on a boundary has a full page of room.
  assign page_room   = PAGE_FULL - {1'b0, addr[PAGE_W-1:0]};
  assign page_beats  = 16'(page_room >> BEAT_SH);
  assign burst_beats = min_beats(min_beats(remaining, MAX_V), page_beats);
  assign last_burst  = (burst_beats == remaining);
  assign pending     = busy && (remaining != 16'd0);
  assign rem_next    = handshake ? (remaining - burst_beats) : remaining;
  assign step        = ADDR_W'(burst_beats) << BEAT_SH;

  // Job state. Completion is detected on the post-handshake remaining count,
  // so a zero-beat job finishes on the edge right after it was accepted and a
  // normal job finishes on the edge of its last handshake. busy drops on the
  // same edge that raises done, which lets a start in the done cycle through.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= 16'd0;
      addr      <= '0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        remaining <= rem_next;
        if (handshake) begin
          addr <= addr + step;
        end
        if (rem_next == 16'd0) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end else if (start) begin
        busy      <= 1'b1;
        remaining <= start_beats;
        addr      <= start_addr & ALIGN_MASK;
      end
    end
  end

endmodule

// File: rtl/axi_ar_sched.sv
// Two-requester AXI read-address burst scheduler.
// Purpose: splits each requester's job into AR bursts (bounded by MAX_BURST
//          and 4 KB pages) and issues them one at a time, alternating between
//          requesters burst by burst when both have work.
// Ports:
//   I_clk, I_rst_n                 clock, synchronous active-low reset
//   I_reqN_start/addr/beats        job start, byte address, length in beats
//   O_reqN_busy / O_reqN_done      job in flight / completion pulse
//   O_arvalid, I_arready           AR handshake
//   O_araddr, O_arlen, O_arid      burst address, beats-1, requester index
module axi_ar_sched
  import cnna_axi_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int BEAT_BYTES = AXI_BEAT_BYTES,
  parameter int MAX_BURST  = AXI_MAX_BURST
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_req0_start,
  input  logic              I_req1_start,
  input  logic [ADDR_W-1:0] I_req0_addr,
  input  logic [ADDR_W-1:0] I_req1_addr,
  input  logic [15:0]       I_req0_beats,
  input  logic [15:0]       I_req1_beats,
  output logic              O_req0_busy,
  output logic              O_req1_busy,
  output logic              O_req0_done,
  output logic              O_req1_done,
  output logic              O_arvalid,
  input  logic              I_arready,
  output logic [ADDR_W-1:0] O_araddr,
  output logic [7:0]        O_arlen,
  output logic              O_arid
);

  ar_state_e         state;
  ar_state_e         state_next;
  logic              handshake;
  logic              grant;
  logic              last_grant;
  logic              more_left;
  logic              pend0, pend1;
  logic              last0, last1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [15:0]       burst0, burst1;
  logic [15:0]       burst_sel;

  assign handshake = (state == ST_ISSUE) && I_arready;
  assign O_arvalid = (state == ST_ISSUE);
  assign burst_sel = grant ? burst1 : burst0;

  axi_ar_req_ctx #(
    .ADDR_W     (ADDR_W),
    .BEAT_BYTES (BEAT_BYTES),
    .MAX_BURST  (MAX_BURST)
  ) u_ctx0 (
    .clk         (I_clk),
    .rst_n       (I_rst_n),
    .start       (I_req0_start),
    .start_addr  (I_req0_addr),
    .start_beats (I_req0_beats),
    .handshake   (handshake && (O_arid == 1'b0)),
    .busy        (O_req0_busy),
    .done        (O_req0_done),
    .pending     (pend0),
    .addr        (addr0),
    .burst_beats (burst0),
    .last_burst  (last0)
  );

  axi_ar_req_ctx #(
    .ADDR_W     (ADDR_W),
    .BEAT_BYTES (BEAT_BYTES),
    .MAX_BURST  (MAX_BURST)
  ) u_ctx1 (
    .clk         (I_clk),
    .rst_n       (I_rst_n),
    .start       (I_req1_start),
    .start_addr  (I_req1_addr),
    .start_beats (I_req1_beats),
    .handshake   (handshake && (O_arid == 1'b1)),
    .busy        (O_req1_busy),
    .done        (O_req1_done),
    .pending     (pend1),
    .addr        (addr1),
    .burst_beats (burst1),
    .last_burst  (last1)
  );

  // FSM state register.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Round-robin grant and next-state logic. more_left looks at the counts as
  // they will be after the current handshake: the granted requester still has
  // beats unless this is its last burst, the other one counts as-is.
  always_comb begin
    state_next = state;
    grant      = pend1;
    if (pend0 && pend1) begin
      grant = ~last_grant;
    end
    more_left = O_arid ? (pend0 || !last1) : (pend1 || !last0);
    case (state)
      ST_IDLE: begin
        if (pend0 || pend1) begin
          state_next = ST_ARB;
        end
      end
      ST_ARB: begin
        state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (I_arready) begin
          state_next = more_left ? ST_ARB : ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Burst attributes are captured when leaving ARB and then held untouched
  // for the whole ISSUE stay. last_grant resets to req1 so req0 wins the
  // first contested arbitration.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      O_araddr   <= '0;
      O_arlen    <= 8'd0;
      O_arid     <= 1'b0;
      last_grant <= 1'b1;
    end else if (state == ST_ARB) begin
      O_araddr   <= grant ? addr1 : addr0;
      O_arlen    <= 8'(burst_sel - 16'd1);
      O_arid     <= grant;
      last_grant <= grant;
    end
  end

endmodule

// File: tb/tb_axi_ar_sched.sv
// Self-checking bench for axi_ar_sched: table-driven single jobs plus
// hand-written sequences for arbitration, stalls, zero-length jobs and reset.
module tb_axi_ar_sched;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic        id;
  } ar_t;

  typedef struct {
    int          req;
    logic [31:0] addr;
    logic [15:0] beats;
    bit          rnd;
    int          n_bursts;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_start = 1'b0, req1_start = 1'b0;
  logic [31:0] req0_addr = '0, req1_addr = '0;
  logic [15:0] req0_beats = '0, req1_beats = '0;
  logic        busy0, busy1, done0, done1;
  logic        arvalid;
  logic        arready = 1'b1;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arid;

  ar_t exp_q[$];
  ar_t obs_q[$];
  int  tests = 0;
  int  fails = 0;
  int  done0_cnt = 0, done1_cnt = 0, av_cnt = 0;
  int  ready_mode = 0;

  axi_ar_sched dut (
    .I_clk        (clk),
    .I_rst_n      (rst_n),
    .I_req0_start (req0_start),
    .I_req1_start (req1_start),
    .I_req0_addr  (req0_addr),
    .I_req1_addr  (req1_addr),
    .I_req0_beats (req0_beats),
    .I_req1_beats (req1_beats),
    .O_req0_busy  (busy0),
    .O_req1_busy  (busy1),
    .O_req0_done  (done0),
    .O_req1_done  (done1),
    .O_arvalid    (arvalid),
    .I_arready    (arready),
    .O_araddr     (araddr),
    .O_arlen      (arlen),
    .O_arid       (arid)
  );

  always #5 clk = ~clk;

  function automatic ar_t mk(input logic [31:0] a, input logic [7:0] l, input logic i);
    ar_t t;
    t.addr = a;
    t.len  = l;
    t.id   = i;
    return t;
  endfunction

  // arready: 0 = always high, 1 = random, otherwise held low
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: arready = 1'b1;
        1: arready = 1'($urandom_range(0, 1));
        default: arready = 1'b0;
      endcase
    end
  end

  // Observe handshakes, done pulses and valid cycles mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (arvalid) av_cnt++;
      if (arvalid && arready) obs_q.push_back(mk(araddr, arlen, arid));
      if (done0) done0_cnt++;
      if (done1) done1_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called on a negedge; the starts are sampled by the next posedge
  task automatic applyStimulus(input logic s0, input logic [31:0] a0, input logic [15:0] b0,
                               input logic s1, input logic [31:0] a1, input logic [15:0] b1);
    req0_start = s0; req0_addr = a0; req0_beats = b0;
    req1_start = s1; req1_addr = a1; req1_beats = b1;
    @(negedge clk);
    req0_start = 1'b0;
    req1_start = 1'b0;
  endtask

  // Reference split of a job into bursts: 16 beats max, never across 4 KB
  task automatic pushModel(input logic id, input logic [31:0] addr, input logic [15:0] beats);
    logic [31:0] a;
    int rem;
    int page;
    int b;
    a = addr & 32'hFFFF_FFF0;
    rem = int'(beats);
    while (rem > 0) begin
      page = (4096 - int'(a % 32'd4096)) / 16;
      b = rem;
      if (b > 16) b = 16;
      if (b > page) b = page;
      exp_q.push_back(mk(a, 8'(b - 1), id));
      a = a + 32'(b * 16);
      rem -= b;
    end
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while ((busy0 || busy1 || arvalid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s_timeout: still busy after %0d cycles, expected idle", name, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic waitArvalid(input string name);
    int n;
    n = 0;
    while (!arvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s_arvalid_timeout: arvalid low for %0d cycles, expected high", name, n);
    end
  endtask

  task automatic compareBursts(input string name);
    ar_t o;
    ar_t e;
    checkOutput({name, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checkOutput({name, "_ar"}, 64'(o), 64'(e));
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  vec_t vecs[7];

  initial begin
    int d0;
    int d1;
    int a;
    int n;

    vecs[0] = '{0, 32'h0000_1000, 16'd40,  1'b0, 3};
    vecs[1] = '{0, 32'h0000_0FC0, 16'd10,  1'b0, 2};
    vecs[2] = '{1, 32'h0000_2004, 16'd16,  1'b1, 1};
    vecs[3] = '{1, 32'h0000_0F00, 16'd100, 1'b1, 7};
    vecs[4] = '{0, 32'hFFFF_FFF0, 16'd3,   1'b0, 2};
    vecs[5] = '{1, 32'h0000_0000, 16'd1,   1'b1, 1};
    vecs[6] = '{0, 32'h0000_3000, 16'd256, 1'b1, 16};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_arvalid", 64'(arvalid), 64'd0);
    checkOutput("rst_busy0",   64'(busy0),   64'd0);
    checkOutput("rst_busy1",   64'(busy1),   64'd0);
    checkOutput("rst_done0",   64'(done0),   64'd0);
    checkOutput("rst_done1",   64'(done1),   64'd0);
    checkOutput("rst_araddr",  64'(araddr),  64'd0);
    checkOutput("rst_arlen",   64'(arlen),   64'd0);
    checkOutput("rst_arid",    64'(arid),    64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Both requesters start together right after reset: req0 wins first
    ready_mode = 0;
    exp_q.push_back(mk(32'h0000_0000, 8'd15, 1'b0));
    exp_q.push_back(mk(32'h0000_8000, 8'd15, 1'b1));
    exp_q.push_back(mk(32'h0000_0100, 8'd15, 1'b0));
    exp_q.push_back(mk(32'h0000_8100, 8'd15, 1'b1));
    d0 = done0_cnt; d1 = done1_cnt;
    applyStimulus(1'b1, 32'h0, 16'd32, 1'b1, 32'h8000, 16'd32);
    waitIdle("rr");
    compareBursts("rr");
    checkOutput("rr_done0", 64'(done0_cnt - d0), 64'd1);
    checkOutput("rr_done1", 64'(done1_cnt - d1), 64'd1);

    // 40-beat job: fixed bursts, arvalid two edges after the accepting edge
    exp_q.push_back(mk(32'h0000_1000, 8'd15, 1'b0));
    exp_q.push_back(mk(32'h0000_1100, 8'd15, 1'b0));
    exp_q.push_back(mk(32'h0000_1200, 8'd7,  1'b0));
    d0 = done0_cnt;
    applyStimulus(1'b1, 32'h1000, 16'd40, 1'b0, 32'h0, 16'd0);
    checkOutput("lat_busy0", 64'(busy0), 64'd1);
    checkOutput("lat_av_e0", 64'(arvalid), 64'd0);
    @(negedge clk);
    checkOutput("lat_av_e1", 64'(arvalid), 64'd0);
    @(negedge clk);
    checkOutput("lat_av_e2", 64'(arvalid), 64'd1);
    waitIdle("lat");
    compareBursts("lat");
    checkOutput("lat_done0", 64'(done0_cnt - d0), 64'd1);

    // Table of single jobs
    for (int i = 0; i < 7; i++) begin
      ready_mode = vecs[i].rnd ? 1 : 0;
      d0 = (vecs[i].req == 1) ? done1_cnt : done0_cnt;
      pushModel(1'(vecs[i].req), vecs[i].addr, vecs[i].beats);
      if (vecs[i].req == 1)
        applyStimulus(1'b0, 32'h0, 16'd0, 1'b1, vecs[i].addr, vecs[i].beats);
      else
        applyStimulus(1'b1, vecs[i].addr, vecs[i].beats, 1'b0, 32'h0, 16'd0);
      waitIdle($sformatf("vec%0d", i));
      n = obs_q.size();
      checkOutput($sformatf("vec%0d_bursts", i), 64'(n), 64'(vecs[i].n_bursts));
      compareBursts($sformatf("vec%0d", i));
      d1 = (vecs[i].req == 1) ? done1_cnt : done0_cnt;
      checkOutput($sformatf("vec%0d_done", i), 64'(d1 - d0), 64'd1);
    end
    ready_mode = 0;

    // arready held low: the ISSUE outputs must not move
    ready_mode = 2;
    pushModel(1'b1, 32'h4000, 16'd20);
    d1 = done1_cnt;
    applyStimulus(1'b0, 32'h0, 16'd0, 1'b1, 32'h4000, 16'd20);
    waitArvalid("stall");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("stall%0d_av", k),   64'(arvalid), 64'd1);
      checkOutput($sformatf("stall%0d_addr", k), 64'(araddr),  64'h4000);
      checkOutput($sformatf("stall%0d_len", k),  64'(arlen),   64'd15);
      checkOutput($sformatf("stall%0d_id", k),   64'(arid),    64'd1);
    end
    ready_mode = 0;
    waitIdle("stall");
    compareBursts("stall");
    checkOutput("stall_done1", 64'(done1_cnt - d1), 64'd1);

    // Zero-beat job on req1
    d1 = done1_cnt;
    a = av_cnt;
    applyStimulus(1'b0, 32'h0, 16'd0, 1'b1, 32'h7000, 16'd0);
    checkOutput("zero_busy_e0", 64'(busy1), 64'd1);
    checkOutput("zero_done_e0", 64'(done1), 64'd0);
    @(negedge clk);
    checkOutput("zero_done_e1", 64'(done1), 64'd1);
    checkOutput("zero_busy_e1", 64'(busy1), 64'd0);
    @(negedge clk);
    checkOutput("zero_done_e2", 64'(done1), 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("zero_no_valid", 64'(av_cnt - a), 64'd0);
    compareBursts("zero");
    checkOutput("zero_done_cnt", 64'(done1_cnt - d1), 64'd1);

    // Reset while a burst sits in ISSUE, then restart
    ready_mode = 2;
    d0 = done0_cnt;
    applyStimulus(1'b1, 32'h1000, 16'd40, 1'b0, 32'h0, 16'd0);
    waitArvalid("abort");
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_arvalid", 64'(arvalid), 64'd0);
    checkOutput("abort_busy0",   64'(busy0),   64'd0);
    checkOutput("abort_done0",   64'(done0),   64'd0);
    rst_n = 1'b1;
    ready_mode = 0;
    repeat (3) @(negedge clk);
    checkOutput("abort_no_done", 64'(done0_cnt - d0), 64'd0);
    compareBursts("abort");
    pushModel(1'b0, 32'h1000, 16'd40);
    applyStimulus(1'b1, 32'h1000, 16'd40, 1'b0, 32'h0, 16'd0);
    waitIdle("restart");
    compareBursts("restart");
    checkOutput("restart_done0", 64'(done0_cnt - d0), 64'd1);

    // req1 starts in a req0 handshake cycle; req0 restarts in its done cycle
    exp_q.push_back(mk(32'h0000_0000, 8'd15, 1'b0));
    exp_q.push_back(mk(32'h0000_9000, 8'd15, 1'b1));
    exp_q.push_back(mk(32'h0000_0100, 8'd15, 1'b0));
    exp_q.push_back(mk(32'h0000_0200, 8'd7,  1'b0));
    exp_q.push_back(mk(32'h0000_5000, 8'd3,  1'b0));
    d0 = done0_cnt; d1 = done1_cnt;
    applyStimulus(1'b1, 32'h0, 16'd40, 1'b0, 32'h0, 16'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("hs_start_av", 64'(arvalid), 64'd1);
    applyStimulus(1'b0, 32'h0, 16'd0, 1'b1, 32'h9000, 16'd16);
    n = 0;
    while (!done0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_cycle_seen", 64'(done0), 64'd1);
    checkOutput("done_cycle_busy0", 64'(busy0), 64'd0);
    applyStimulus(1'b1, 32'h5000, 16'd4, 1'b0, 32'h0, 16'd0);
    checkOutput("done_cycle_restart", 64'(busy0), 64'd1);
    waitIdle("hs");
    compareBursts("hs");
    checkOutput("hs_done0", 64'(done0_cnt - d0), 64'd2);
    checkOutput("hs_done1", 64'(done1_cnt - d1), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
